// File: rtl/write_buffer.sv
// write_buffer: packs an acquisition byte stream into 16-bit little-endian
// words, queues them in a small word FIFO and writes them to external memory
// over a command/acknowledge handshake, counting completed rows for the
// downstream read stage.
module write_buffer #(
  parameter int FIFO_DEPTH    = 8,
  parameter int WORDS_PER_ROW = 256,
  parameter int COL_BITS      = 8
) (
  input  logic                    CLK_48MHZ,
  input  logic                    RESET,
  input  logic [7:0]              BYTE_IN,
  input  logic                    BYTE_VALID,
  input  logic                    FLUSH,
  input  logic                    MEM_ACK,
  output logic                    WRITE_CMD,
  output logic [15:0]             DATA_WRITE,
  output logic [13+COL_BITS-1:0]  WRITE_ADDR,
  output logic [12:0]             ROW_WRITE,
  output logic                    OVERFLOW
);

  localparam int                 PTR_W      = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]     C_FULL     = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [COL_BITS-1:0] C_LAST_COL = COL_BITS'(WORDS_PER_ROW - 1);
  localparam logic [12:0]        C_ROW_MAX  = 13'h1FFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // byte packing
  logic                r_phase;
  logic [7:0]          r_held;
  logic                w_phase_nxt;
  logic [7:0]          w_held_nxt;
  logic                w_push;
  logic [15:0]         w_push_data;

  // word FIFO
  logic [15:0]         r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [PTR_W:0]      r_count;
  logic                r_overflow;
  logic                w_full;
  logic                w_empty;
  logic                w_pop;
  logic                w_push_ok;
  logic                w_drop;

  // write FSM and memory-side registers
  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_write_cmd;
  logic [15:0]         r_data_write;
  logic [13+COL_BITS-1:0] r_write_addr;
  logic [COL_BITS-1:0] r_col;
  logic [12:0]         r_row;
  logic                w_cmd_nxt;
  logic [15:0]         w_data_nxt;
  logic [13+COL_BITS-1:0] w_addr_nxt;
  logic [COL_BITS-1:0] w_col_nxt;
  logic [12:0]         w_row_nxt;

  // Pair bytes low-first; a same-cycle FLUSH pads a freshly started pair
  always_comb begin
    w_push      = 1'b0;
    w_push_data = 16'h0000;
    w_phase_nxt = r_phase;
    w_held_nxt  = r_held;
    if (BYTE_VALID) begin
      if (r_phase) begin
        w_push      = 1'b1;
        w_push_data = {BYTE_IN, r_held};
        w_phase_nxt = 1'b0;
      end else begin
        w_held_nxt = BYTE_IN;
        if (FLUSH) begin
          w_push      = 1'b1;
          w_push_data = {8'h00, BYTE_IN};
          w_phase_nxt = 1'b0;
        end else begin
          w_phase_nxt = 1'b1;
        end
      end
    end else if (FLUSH && r_phase) begin
      w_push      = 1'b1;
      w_push_data = {8'h00, r_held};
      w_phase_nxt = 1'b0;
    end else begin
      w_phase_nxt = r_phase;
    end
  end

  // Holding register and byte-phase flag
  always_ff @(posedge CLK_48MHZ or negedge RESET) begin
    if (!RESET) begin
      r_phase <= 1'b0;
      r_held  <= 8'h00;
    end else begin
      r_phase <= w_phase_nxt;
      r_held  <= w_held_nxt;
    end
  end

  // FIFO status; a pop on the same edge frees the slot for a push when full
  always_comb begin
    w_full    = (r_count == C_FULL);
    w_empty   = (r_count == {(PTR_W+1){1'b0}});
    w_pop     = (r_state == ST_ISSUE) && MEM_ACK;
    w_push_ok = w_push && (!w_full || w_pop);
    w_drop    = w_push && w_full && !w_pop;
  end

  // FIFO storage, pointers, occupancy and sticky overflow
  always_ff @(posedge CLK_48MHZ or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= 16'h0000;
      end
      r_wr_ptr   <= {PTR_W{1'b0}};
      r_rd_ptr   <= {PTR_W{1'b0}};
      r_count    <= {(PTR_W+1){1'b0}};
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= w_push_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1'b1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1'b1);
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1'b1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1'b1);
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Write FSM next state and next values of the memory-side registers
  always_comb begin
    w_state_nxt = r_state;
    w_cmd_nxt   = r_write_cmd;
    w_data_nxt  = r_data_write;
    w_addr_nxt  = r_write_addr;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_state_nxt = ST_ISSUE;
          w_cmd_nxt   = 1'b1;
          w_data_nxt  = r_mem[r_rd_ptr];
          w_addr_nxt  = {r_row, r_col};
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (MEM_ACK) begin
          w_state_nxt = ST_GAP;
          w_cmd_nxt   = 1'b0;
          w_col_nxt   = r_col + COL_BITS'(1'b1);
          // row stops at its maximum; columns keep wrapping within it
          if ((r_col == C_LAST_COL) && (r_row != C_ROW_MAX)) begin
            w_row_nxt = r_row + 13'd1;
          end else begin
            w_row_nxt = r_row;
          end
        end else begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_GAP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cmd_nxt   = 1'b0;
      end
    endcase
  end

  // Write FSM state register
  always_ff @(posedge CLK_48MHZ or negedge RESET) begin
    if (!RESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered command, data, address, column and row count
  always_ff @(posedge CLK_48MHZ or negedge RESET) begin
    if (!RESET) begin
      r_write_cmd  <= 1'b0;
      r_data_write <= 16'h0000;
      r_write_addr <= {(13+COL_BITS){1'b0}};
      r_col        <= {COL_BITS{1'b0}};
      r_row        <= 13'd0;
    end else begin
      r_write_cmd  <= w_cmd_nxt;
      r_data_write <= w_data_nxt;
      r_write_addr <= w_addr_nxt;
      r_col        <= w_col_nxt;
      r_row        <= w_row_nxt;
    end
  end

  assign WRITE_CMD  = r_write_cmd;
  assign DATA_WRITE = r_data_write;
  assign WRITE_ADDR = r_write_addr;
  assign ROW_WRITE  = r_row;
  assign OVERFLOW   = r_overflow;

endmodule

// File: tb/tb_write_buffer.sv
// tb_write_buffer: directed scenarios plus randomized traffic for
// write_buffer, checked against a queue-based reference model.
module tb_write_buffer;

  localparam int FD  = 8;
  localparam int WPR = 256;

  logic        clk;
  logic        reset_n;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        flush;
  logic        mem_ack;
  logic        write_cmd;
  logic [15:0] data_write;
  logic [20:0] write_addr;
  logic [12:0] row_write;
  logic        overflow;

  write_buffer #(.FIFO_DEPTH(FD), .WORDS_PER_ROW(WPR), .COL_BITS(8)) dut (
    .CLK_48MHZ  (clk),
    .RESET      (reset_n),
    .BYTE_IN    (byte_in),
    .BYTE_VALID (byte_valid),
    .FLUSH      (flush),
    .MEM_ACK    (mem_ack),
    .WRITE_CMD  (write_cmd),
    .DATA_WRITE (data_write),
    .WRITE_ADDR (write_addr),
    .ROW_WRITE  (row_write),
    .OVERFLOW   (overflow)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // reference model: words accepted but not yet acknowledged, in order
  logic [15:0] q[$];
  logic        m_phase;
  logic [7:0]  m_held;
  logic        exp_ovf;
  int          wcount;
  // ack policy and handshake history
  int          ack_dly;
  bit          ack_hold;
  bit          spur_en;
  bit          force_ack;
  bit          prev_cmd;
  bit          prev_ack;
  int          low_cnt;
  int          hi_cnt;

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int exp_row();
    int r;
    r = wcount / WPR;
    if (r > 8191) r = 8191;
    return r;
  endfunction

  function automatic int exp_addr();
    return exp_row() * WPR + (wcount % WPR);
  endfunction

  // Checks after every edge: handshake rules, write contents, row count, overflow
  task automatic monitor();
    if (prev_cmd && !prev_ack) check_val("cmd_hold", 32'(write_cmd), 32'd1);
    if (prev_cmd && prev_ack)  check_val("cmd_drop_after_ack", 32'(write_cmd), 32'd0);
    if (write_cmd && !prev_cmd) check_val("req_gap_ge2", 32'(low_cnt >= 2), 32'd1);
    if (write_cmd) begin
      if (q.size() == 0) begin
        check_val("unexpected_write", 32'(write_cmd), 32'd0);
      end else begin
        check_val("data_write", 32'(data_write), 32'(q[0]));
        check_val("write_addr", 32'(write_addr), 32'(exp_addr()));
      end
      low_cnt = 0;
      hi_cnt++;
    end else begin
      low_cnt++;
      hi_cnt = 0;
    end
    check_val("row_write", 32'(row_write), 32'(exp_row()));
    check_val("overflow", 32'(overflow), 32'(exp_ovf));
  endtask

  // One clock: choose ack, advance the model for the coming edge, then check
  task automatic step();
    bit          pop;
    bit          push;
    logic [15:0] pw;
    push = 1'b0;
    pw   = 16'h0000;
    if (force_ack) mem_ack = 1'b1;
    else if (write_cmd && !ack_hold && hi_cnt >= ack_dly) mem_ack = 1'b1;
    else if (!write_cmd && spur_en && $urandom_range(0, 3) == 0) mem_ack = 1'b1;
    else mem_ack = 1'b0;
    pop = mem_ack && write_cmd;
    if (byte_valid) begin
      if (m_phase) begin
        push = 1'b1; pw = {byte_in, m_held}; m_phase = 1'b0;
      end else begin
        m_held = byte_in;
        if (flush) begin
          push = 1'b1; pw = {8'h00, byte_in}; m_phase = 1'b0;
        end else begin
          m_phase = 1'b1;
        end
      end
    end else if (flush && m_phase) begin
      push = 1'b1; pw = {8'h00, m_held}; m_phase = 1'b0;
    end
    if (push && !(q.size() < FD || pop)) begin
      exp_ovf = 1'b1;
      push    = 1'b0;
    end
    if (pop) begin
      void'(q.pop_front());
      wcount++;
    end
    if (push) q.push_back(pw);
    prev_cmd = write_cmd;
    prev_ack = mem_ack;
    @(posedge clk);
    @(negedge clk);
    byte_valid = 1'b0;
    flush      = 1'b0;
    force_ack  = 1'b0;
    monitor();
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_in    = b;
    step();
  endtask

  task automatic send_flush();
    flush = 1'b1;
    step();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((q.size() != 0 || write_cmd) && n < budget) begin
      step();
      n++;
    end
    check_val("drain_in_budget", 32'(n < budget), 32'd1);
  endtask

  task automatic wait_cmd(input int budget);
    int n;
    n = 0;
    while (!write_cmd && n < budget) begin
      step();
      n++;
    end
    check_val("cmd_in_budget", 32'(write_cmd), 32'd1);
  endtask

  // Asynchronous reset applied between edges; outputs must clear at once
  task automatic do_reset();
    reset_n = 1'b0;
    mem_ack = 1'b0;
    byte_valid = 1'b0;
    flush = 1'b0;
    #1;
    check_val("rst_write_cmd", 32'(write_cmd), 32'd0);
    check_val("rst_data_write", 32'(data_write), 32'd0);
    check_val("rst_write_addr", 32'(write_addr), 32'd0);
    check_val("rst_row_write", 32'(row_write), 32'd0);
    check_val("rst_overflow", 32'(overflow), 32'd0);
    q.delete();
    m_phase = 1'b0; m_held = 8'h00; exp_ovf = 1'b0; wcount = 0;
    prev_cmd = 1'b0; prev_ack = 1'b0; low_cnt = 2; hi_cnt = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b1; byte_in = 8'h00; byte_valid = 1'b0; flush = 1'b0; mem_ack = 1'b0;
    ack_dly = 1; ack_hold = 1'b0; spur_en = 1'b0; force_ack = 1'b0;
    @(negedge clk);
    do_reset();

    // first pair: latency of two edges after the push, ack three cycles later
    ack_dly = 3;
    send_byte(8'h11);
    send_byte(8'h22);
    check_val("lat_edge1_low", 32'(write_cmd), 32'd0);
    step();
    check_val("lat_edge2_high", 32'(write_cmd), 32'd1);
    check_val("first_word", 32'(data_write), 32'h2211);
    drain(50);

    // single byte padded by FLUSH; second FLUSH is a no-op
    ack_dly = 1;
    send_byte(8'hAB);
    send_flush();
    drain(50);
    check_val("flush_writes", 32'(wcount), 32'd2);
    send_flush();
    repeat (4) step();
    check_val("flush_idle_no_write", 32'(write_cmd), 32'd0);
    check_val("flush_again_writes", 32'(wcount), 32'd2);

    // three full rows, one byte every other cycle
    do_reset();
    ack_dly = 1;
    for (int i = 0; i < 2 * WPR * 3; i++) begin
      send_byte(8'($urandom_range(0, 255)));
      step();
    end
    drain(200);
    check_val("rows_done", 32'(row_write), 32'd3);
    check_val("rows_words", 32'(wcount), 32'd768);

    // reset while a request is outstanding
    ack_hold = 1'b1;
    send_byte(8'h5A);
    send_byte(8'hC3);
    wait_cmd(10);
    do_reset();
    ack_hold = 1'b0;
    ack_dly = 2;
    send_byte(8'h01);
    send_byte(8'h02);
    wait_cmd(10);
    check_val("post_reset_addr", 32'(write_addr), 32'd0);
    check_val("post_reset_data", 32'(data_write), 32'h0201);
    drain(50);

    // overflow: ack withheld while nine words arrive
    do_reset();
    ack_hold = 1'b1;
    for (int i = 0; i < 2 * (FD + 1); i++) send_byte(8'(i + 1));
    step();
    check_val("ovf_set", 32'(overflow), 32'd1);
    ack_hold = 1'b0;
    ack_dly = 1;
    drain(200);
    check_val("ovf_words_written", 32'(wcount), 32'(FD));

    // full FIFO, pair completes on the ack edge
    do_reset();
    ack_hold = 1'b1;
    for (int i = 0; i < 2 * FD; i++) send_byte(8'($urandom_range(0, 255)));
    repeat (3) step();
    check_val("full_no_ovf", 32'(overflow), 32'd0);
    send_byte(8'hA1);
    force_ack = 1'b1;
    send_byte(8'hA2);
    check_val("full_ack_push_no_ovf", 32'(overflow), 32'd0);
    ack_hold = 1'b0;
    ack_dly = 1;
    drain(200);
    check_val("full_ack_words", 32'(wcount), 32'(FD + 1));

    // randomized traffic with random ack delays and stray acks
    do_reset();
    spur_en = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if (!write_cmd) ack_dly = $urandom_range(1, 4);
      byte_valid = ($urandom_range(0, 9) < 4);
      byte_in    = 8'($urandom_range(0, 255));
      flush      = ($urandom_range(0, 19) == 0);
      step();
    end
    spur_en = 1'b0;
    ack_dly = 1;
    drain(400);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/write_buffer.md
Name: write_buffer

Overview:
Upstream stage of the memory read path. Packs the byte stream from the acquisition side into 16-bit little-endian words, queues them in a small word FIFO, and writes them to external memory over a command/acknowledge handshake. Maintains ROW_WRITE, the count of fully written rows, which the downstream read stage polls before it starts reading.

Parameters:
FIFO_DEPTH, 8, word FIFO depth; power of two, minimum 2.
WORDS_PER_ROW, 256, words per memory row; power of two.
COL_BITS, 8, log2(WORDS_PER_ROW).

Ports:
CLK_48MHZ  input  1  system clock; all logic on the rising edge.
RESET  input  1  asynchronous, active-low reset.
BYTE_IN  input  8  data byte, sampled when BYTE_VALID=1.
BYTE_VALID  input  1  one-cycle strobe per byte; may be asserted on consecutive cycles.
FLUSH  input  1  one-cycle strobe; forces out a pending half word.
MEM_ACK  input  1  one-cycle pulse from the memory controller when the current write has completed.
WRITE_CMD  output  1  write request to the memory controller.
DATA_WRITE  output  16  word being written.
WRITE_ADDR  output  13+COL_BITS  address as {row, column}.
ROW_WRITE  output  13  number of completed rows.
OVERFLOW  output  1  sticky flag; a word was dropped because the FIFO was full.

Behaviour:
- Reset (asynchronous, RESET=0): WRITE_CMD=0, DATA_WRITE=0, WRITE_ADDR=0, ROW_WRITE=0, OVERFLOW=0. The byte-phase flag, FIFO pointers and count, column and row are all cleared. Reset mid-write abandons the transfer; WRITE_CMD drops asynchronously.
- Packing:
  - First byte of a pair goes to the holding register [7:0] and sets the phase flag.
  - Second byte forms the word {BYTE_IN, held} and pushes it into the FIFO in the same cycle; the phase flag clears.
  - The low byte is therefore always the earlier byte, matching the low-byte-first order of the read stage.
- FLUSH:
  - With the phase flag set, FLUSH pushes {8'h00, held} and clears the flag.
  - With the flag clear, FLUSH does nothing.
  - If BYTE_VALID and FLUSH arrive in the same cycle, the byte is processed first. A byte completing a pair pushes that pair and FLUSH does nothing; a byte starting a new pair is padded and pushed by FLUSH.
- FIFO:
  - Push and pop in the same cycle are allowed, including when the FIFO is full; the count is unchanged.
  - A push while full with no pop in that cycle drops the word and sets OVERFLOW. OVERFLOW clears only on reset.
  - Pointers wrap modulo FIFO_DEPTH.
- Write FSM (IDLE, ISSUE, GAP):
  - IDLE: if the FIFO is non-empty, on the next edge load DATA_WRITE from the FIFO head, set WRITE_ADDR={row, col}, set WRITE_CMD=1, and go to ISSUE.
  - ISSUE: WRITE_CMD, DATA_WRITE and WRITE_ADDR are held stable until MEM_ACK=1 is sampled. On that edge: WRITE_CMD=0, pop the FIFO, col=col+1, go to GAP. MEM_ACK outside ISSUE is ignored.
  - GAP: one cycle with WRITE_CMD=0, then go to IDLE. Minimum spacing between requests is 2 cycles of WRITE_CMD low.
  - Latency: a word pushed into an empty FIFO raises WRITE_CMD 2 edges after the push edge (edge 1 makes the FIFO non-empty, edge 2 issues).
- Row accounting:
  - When col wraps from WORDS_PER_ROW-1 to 0 on an ack, row=row+1 and ROW_WRITE=row+1 on that same edge.
  - ROW_WRITE saturates at 13'h1FFF. Once saturated, further writes keep going to row 8191 and col keeps wrapping.
- Arithmetic: all counters are unsigned, with widths exactly as declared. ROW_WRITE is registered and glitch-free.

Test Plan:
- Reset, then bytes 0x11, 0x22 on consecutive cycles, with MEM_ACK returned 3 cycles after WRITE_CMD -> WRITE_CMD=1 two edges after the push, DATA_WRITE=0x2211, WRITE_ADDR=0. WRITE_CMD is low the cycle after the ack. ROW_WRITE=0.
- Byte 0xAB, then FLUSH -> one write with DATA_WRITE=0x00AB. A second FLUSH produces no write.
- Stream 2*WORDS_PER_ROW*3 bytes (1536) with MEM_ACK one cycle after each request -> ROW_WRITE steps 0→1→2→3, and each step occurs on the ack of a column-255 word. Addresses are contiguous 0..767.
- Hold MEM_ACK low, stream 2*(FIFO_DEPTH+1) bytes, then release ack -> OVERFLOW=1 after the 9th word. Exactly words 1–8 are written in order; WRITE_CMD never drops without an ack.
- Full FIFO, with a pair completing on the same edge as an ack -> no overflow, count stays 8, and the new word is written last.
- Assert RESET low while WRITE_CMD=1 in ISSUE -> WRITE_CMD=0 immediately and ROW_WRITE=0. After release, the next pair is written at address 0.
